// File: rtl/move_arbiter.sv
// ---------------------------------------------------------------------------
// move_arbiter
//
// Decides, once per frame, which single piece action the game performs:
// clearing completed rows, applying gravity (fall or lock), or one of the
// player moves (left, right, rotate). Player keys have per-key auto-repeat.
// A held key is granted once, then again after REPEAT_DELAY frame ticks,
// then every REPEAT_RATE frame ticks while it stays held.
//
// Ports
//   clock          single clock, rising edge
//   resetn         asynchronous active-low reset
//   frame_tick     one-cycle frame enable; arbitration happens only here
//   game_active    level; low suppresses grants and idles all key state
//   fall_req       one-cycle gravity request, latched into fall_pending
//   clear_req      level; completed rows are waiting to be removed
//   key_left/key_right/key_rotate              raw key levels
//   blocked_left/right/rotate/down             the move would collide
//   grant_clear/fall/lock/left/right/rotate    registered one-hot pulses
//   fall_pending   a gravity request is latched and not yet serviced
//
// REPEAT_DELAY and REPEAT_RATE must both be at least 1.
// ---------------------------------------------------------------------------
module move_arbiter #(
  parameter int REPEAT_DELAY = 15,
  parameter int REPEAT_RATE  = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic frame_tick,
  input  logic game_active,
  input  logic fall_req,
  input  logic clear_req,
  input  logic key_left,
  input  logic key_right,
  input  logic key_rotate,
  input  logic blocked_left,
  input  logic blocked_right,
  input  logic blocked_rotate,
  input  logic blocked_down,
  output logic grant_clear,
  output logic grant_fall,
  output logic grant_lock,
  output logic grant_left,
  output logic grant_right,
  output logic grant_rotate,
  output logic fall_pending
);

  localparam int NUM_KEYS = 3;
  localparam int MAX_WAIT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  // The tick on which the count would reach its target is itself the
  // re-armed tick, so the gap between grants is exactly DELAY / RATE ticks.
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] DELAY_MAX  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] RATE_MAX   = CNT_W'(REPEAT_RATE);

  typedef enum logic [1:0] {
    KEY_IDLE   = 2'd0,
    KEY_ARMED  = 2'd1,
    KEY_DELAY  = 2'd2,
    KEY_REPEAT = 2'd3
  } key_state_t;

  // Key vectors are indexed 0 = left, 1 = right, 2 = rotate, which is also
  // their arbitration order.
  key_state_t          key_state [NUM_KEYS];
  logic [CNT_W-1:0]    key_cnt   [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_blocked;
  logic [NUM_KEYS-1:0] key_frozen;
  logic [NUM_KEYS-1:0] key_armed;
  logic [NUM_KEYS-1:0] key_eligible;
  logic [NUM_KEYS-1:0] key_win;
  logic                tick_seen;
  logic                arb_enable;
  logic                win_clear;
  logic                win_fall;

  assign key_level   = {key_rotate, key_right, key_left};
  assign key_blocked = {blocked_rotate, blocked_right, blocked_left};

  // Left and right pressed together cancel each other and hold their state.
  assign key_frozen  = {1'b0, {2{key_left & key_right}}};

  // A key is armed when it is freshly pressed, or when its auto-repeat
  // wait expires on the current frame tick.
  always_comb begin
    key_armed = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      case (key_state[i])
        KEY_ARMED:  key_armed[i] = 1'b1;
        KEY_DELAY:  key_armed[i] = (key_cnt[i] >= DELAY_LAST);
        KEY_REPEAT: key_armed[i] = (key_cnt[i] >= RATE_LAST);
        default:    key_armed[i] = 1'b0;
      endcase
    end
  end

  // Fixed-priority arbitration: clear > pending fall > left > right > rotate.
  // Nothing is granted on the first frame tick after reset so that the key
  // state machines and the gravity latch have settled for one whole frame.
  always_comb begin
    arb_enable   = frame_tick & game_active & tick_seen;
    key_eligible = key_level & key_armed & ~key_blocked & ~key_frozen;
    win_clear    = arb_enable & clear_req;
    win_fall     = arb_enable & ~clear_req & fall_pending;
    key_win      = '0;
    if (arb_enable && !clear_req && !fall_pending) begin
      if (key_eligible[0]) begin
        key_win[0] = 1'b1;
      end else if (key_eligible[1]) begin
        key_win[1] = 1'b1;
      end else if (key_eligible[2]) begin
        key_win[2] = 1'b1;
      end
    end
  end

  // Per-key auto-repeat state machines. Releasing a key or leaving the game
  // always returns to IDLE; otherwise a grant moves the key on and the wait
  // counter advances only on frame ticks, saturating at its target so an
  // armed request that loses or is blocked stays armed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_state[i] <= KEY_IDLE;
        key_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!game_active || !key_level[i]) begin
          key_state[i] <= KEY_IDLE;
          key_cnt[i]   <= '0;
        end else if (!key_frozen[i]) begin
          case (key_state[i])
            KEY_IDLE: begin
              key_state[i] <= KEY_ARMED;
              key_cnt[i]   <= '0;
            end
            KEY_ARMED: begin
              if (key_win[i]) begin
                key_state[i] <= KEY_DELAY;
                key_cnt[i]   <= '0;
              end
            end
            KEY_DELAY: begin
              if (key_win[i]) begin
                key_state[i] <= KEY_REPEAT;
                key_cnt[i]   <= '0;
              end else if (frame_tick && key_cnt[i] < DELAY_MAX) begin
                key_cnt[i]   <= key_cnt[i] + 1'b1;
              end
            end
            KEY_REPEAT: begin
              if (key_win[i]) begin
                key_cnt[i]   <= '0;
              end else if (frame_tick && key_cnt[i] < RATE_MAX) begin
                key_cnt[i]   <= key_cnt[i] + 1'b1;
              end
            end
            default: begin
              key_state[i] <= KEY_IDLE;
              key_cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Registered grant pulses, the gravity latch and the first-tick flag.
  // A fall_req arriving on the servicing tick wins over the clear, so a new
  // gravity request is never dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      grant_clear  <= 1'b0;
      grant_fall   <= 1'b0;
      grant_lock   <= 1'b0;
      grant_left   <= 1'b0;
      grant_right  <= 1'b0;
      grant_rotate <= 1'b0;
      fall_pending <= 1'b0;
      tick_seen    <= 1'b0;
    end else begin
      grant_clear  <= win_clear;
      grant_fall   <= win_fall & ~blocked_down;
      grant_lock   <= win_fall & blocked_down;
      grant_left   <= key_win[0];
      grant_right  <= key_win[1];
      grant_rotate <= key_win[2];
      if (frame_tick) begin
        tick_seen <= 1'b1;
      end
      if (!game_active) begin
        fall_pending <= 1'b0;
      end else if (fall_req) begin
        fall_pending <= 1'b1;
      end else if (win_fall) begin
        fall_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_move_arbiter.sv
// ---------------------------------------------------------------------------
// tb_move_arbiter
//
// Frame-level bench for move_arbiter. Each frame sets the input levels,
// optionally pulses fall_req, then issues one frame_tick. A frame-level
// reference model (countdown per key, priority list) predicts which grant
// each tick produces and queues it; a monitor pops the queue whenever the
// DUT shows a grant pulse.
// ---------------------------------------------------------------------------
module tb_move_arbiter;

  localparam int DELAY = 15;
  localparam int RATE  = 4;

  localparam int CODE_NONE   = 0;
  localparam int CODE_CLEAR  = 1;
  localparam int CODE_FALL   = 2;
  localparam int CODE_LOCK   = 3;
  localparam int CODE_LEFT   = 4;
  localparam int CODE_RIGHT  = 5;
  localparam int CODE_ROTATE = 6;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0;
  logic game_active = 1'b0;
  logic fall_req = 1'b0;
  logic clear_req = 1'b0;
  logic key_left = 1'b0;
  logic key_right = 1'b0;
  logic key_rotate = 1'b0;
  logic blocked_left = 1'b0;
  logic blocked_right = 1'b0;
  logic blocked_rotate = 1'b0;
  logic blocked_down = 1'b0;
  logic grant_clear;
  logic grant_fall;
  logic grant_lock;
  logic grant_left;
  logic grant_right;
  logic grant_rotate;
  logic fall_pending;

  typedef struct packed {
    logic ga;
    logic clr;
    logic fall_mid;
    logic fall_tick;
    logic kl;
    logic kr;
    logic kro;
    logic bl;
    logic br;
    logic bro;
    logic bd;
  } frame_t;

  typedef struct {
    int tick;
    int code;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int tick_count = 0;
  int left_grants = 0;

  bit m_seen;
  bit m_pending;
  bit m_pressed [3];
  bit m_once    [3];
  int m_rem     [3];

  move_arbiter #(
    .REPEAT_DELAY(DELAY),
    .REPEAT_RATE (RATE)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .game_active   (game_active),
    .fall_req      (fall_req),
    .clear_req     (clear_req),
    .key_left      (key_left),
    .key_right     (key_right),
    .key_rotate    (key_rotate),
    .blocked_left  (blocked_left),
    .blocked_right (blocked_right),
    .blocked_rotate(blocked_rotate),
    .blocked_down  (blocked_down),
    .grant_clear   (grant_clear),
    .grant_fall    (grant_fall),
    .grant_lock    (grant_lock),
    .grant_left    (grant_left),
    .grant_right   (grant_right),
    .grant_rotate  (grant_rotate),
    .fall_pending  (fall_pending)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Safety net so the run always ends even if stimulus stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: forget everything, first tick after reset grants nothing.
  task automatic modelReset();
    m_seen = 1'b0;
    m_pending = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_pressed[i] = 1'b0;
      m_once[i] = 1'b0;
      m_rem[i] = 0;
    end
  endtask

  // Reference model: effect of the frame's input levels before the tick.
  // A newly pressed key needs no wait; a released key forgets its history.
  task automatic modelLevels(input frame_t f);
    bit [2:0] keys;
    bit both;
    keys = {f.kro, f.kr, f.kl};
    both = f.kl && f.kr;
    for (int i = 0; i < 3; i++) begin
      if (!f.ga || !keys[i]) begin
        m_pressed[i] = 1'b0;
        m_once[i] = 1'b0;
        m_rem[i] = 0;
      end else if (!(both && i < 2) && !m_pressed[i]) begin
        m_pressed[i] = 1'b1;
        m_once[i] = 1'b0;
        m_rem[i] = 0;
      end
    end
    if (!f.ga) begin
      m_pending = 1'b0;
    end else if (f.fall_mid) begin
      m_pending = 1'b1;
    end
  endtask

  // Reference model: one frame tick. Each key counts down the ticks left
  // until it may be granted again; priority picks the single winner.
  task automatic modelTick(input frame_t f, output int code);
    bit [2:0] blocked;
    bit both;
    bit elig [3];
    code = CODE_NONE;
    blocked = {f.bro, f.br, f.bl};
    both = f.kl && f.kr;
    if (!f.ga) begin
      m_pending = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_pressed[i] && !(both && i < 2) && m_rem[i] > 0) begin
          m_rem[i] = m_rem[i] - 1;
        end
        elig[i] = m_pressed[i] && !(both && i < 2) && m_rem[i] == 0 && !blocked[i];
      end
      if (m_seen) begin
        if (f.clr) begin
          code = CODE_CLEAR;
        end else if (m_pending) begin
          code = f.bd ? CODE_LOCK : CODE_FALL;
          m_pending = 1'b0;
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (code == CODE_NONE && elig[i]) begin
              code = CODE_LEFT + i;
              m_rem[i] = m_once[i] ? RATE : DELAY;
              m_once[i] = 1'b1;
            end
          end
        end
      end
      if (f.fall_tick) begin
        m_pending = 1'b1;
      end
    end
    m_seen = 1'b1;
  endtask

  // One frame: levels (plus optional gravity pulse), two settle cycles,
  // then a single frame_tick cycle.
  task automatic applyStimulus(input frame_t f);
    int code;
    exp_t e;
    @(negedge clock);
    game_active = f.ga;
    clear_req = f.clr;
    key_left = f.kl;
    key_right = f.kr;
    key_rotate = f.kro;
    blocked_left = f.bl;
    blocked_right = f.br;
    blocked_rotate = f.bro;
    blocked_down = f.bd;
    fall_req = f.fall_mid;
    modelLevels(f);
    @(negedge clock);
    fall_req = 1'b0;
    checkOutput("fall_pending_frame", fall_pending, m_pending);
    @(negedge clock);
    frame_tick = 1'b1;
    fall_req = f.fall_tick;
    tick_count++;
    modelTick(f, code);
    if (code != CODE_NONE) begin
      e.tick = tick_count;
      e.code = code;
      exp_q.push_back(e);
    end
    @(negedge clock);
    frame_tick = 1'b0;
    fall_req = 1'b0;
    checkOutput("fall_pending_tick", fall_pending, m_pending);
  endtask

  // Reset with every request active: outputs must stay at zero.
  task automatic resetDut();
    @(negedge clock);
    resetn = 1'b0;
    game_active = 1'b1;
    clear_req = 1'b1;
    key_left = 1'b1;
    fall_req = 1'b1;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    fall_req = 1'b0;
    @(negedge clock);
    checkOutput("reset_grant_clear", grant_clear, 1'b0);
    checkOutput("reset_grant_fall", grant_fall, 1'b0);
    checkOutput("reset_grant_lock", grant_lock, 1'b0);
    checkOutput("reset_grant_left", grant_left, 1'b0);
    checkOutput("reset_grant_right", grant_right, 1'b0);
    checkOutput("reset_grant_rotate", grant_rotate, 1'b0);
    checkOutput("reset_fall_pending", fall_pending, 1'b0);
    game_active = 1'b0;
    clear_req = 1'b0;
    key_left = 1'b0;
    key_right = 1'b0;
    key_rotate = 1'b0;
    blocked_left = 1'b0;
    blocked_right = 1'b0;
    blocked_rotate = 1'b0;
    blocked_down = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    modelReset();
  endtask

  // Monitor: every visible grant pulse must be one-hot and match the next
  // queued prediction, including the tick that produced it.
  logic [5:0] mon_gvec;
  int mon_code;
  exp_t mon_e;
  always @(negedge clock) begin
    if (resetn) begin
      mon_gvec = {grant_rotate, grant_right, grant_left, grant_lock, grant_fall, grant_clear};
      if (mon_gvec != 6'b0) begin
        if (grant_left) begin
          left_grants++;
        end
        checks++;
        if ($countones(mon_gvec) != 1) begin
          failures++;
          $display("[TB] FAIL grant_onehot: got grants %06b required exactly one bit", mon_gvec);
        end
        mon_code = CODE_NONE;
        for (int b = 0; b < 6; b++) begin
          if (mon_gvec[b]) begin
            mon_code = b + 1;
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL grant_unexpected: got code %0d at tick %0d required no grant", mon_code, tick_count);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.code != mon_code || mon_e.tick != tick_count) begin
            failures++;
            $display("[TB] FAIL grant_seq: got code %0d at tick %0d required code %0d at tick %0d",
                     mon_code, tick_count, mon_e.code, mon_e.tick);
          end
        end
      end
    end
  end

  frame_t f;
  bit rk [3];
  bit rga;

  initial begin
    modelReset();
    resetDut();

    // First tick after release is only a settle frame; then hold left 40 ticks.
    f = '0;
    f.ga = 1'b1;
    f.kl = 1'b1;
    applyStimulus(f);
    @(negedge clock);
    left_grants = 0;
    for (int t = 0; t < 40; t++) begin
      applyStimulus(f);
    end
    @(negedge clock);
    checkCount("left_hold_40_grants", left_grants, 8);

    // Gravity and right key in the same frame: fall first, right next tick.
    f = '0;
    f.ga = 1'b1;
    applyStimulus(f);
    f.fall_mid = 1'b1;
    f.kr = 1'b1;
    applyStimulus(f);
    f.fall_mid = 1'b0;
    applyStimulus(f);

    // Blocked gravity locks the piece and empties the latch.
    f = '0;
    f.ga = 1'b1;
    f.fall_mid = 1'b1;
    f.bd = 1'b1;
    applyStimulus(f);
    f.fall_mid = 1'b0;
    applyStimulus(f);

    // Row clears outrank a pending fall, which waits for three frames.
    f = '0;
    f.ga = 1'b1;
    f.clr = 1'b1;
    f.fall_mid = 1'b1;
    applyStimulus(f);
    f.fall_mid = 1'b0;
    applyStimulus(f);
    applyStimulus(f);
    f.clr = 1'b0;
    applyStimulus(f);

    // A new request on the servicing tick keeps the latch set.
    f = '0;
    f.ga = 1'b1;
    f.fall_mid = 1'b1;
    f.fall_tick = 1'b1;
    applyStimulus(f);
    f = '0;
    f.ga = 1'b1;
    applyStimulus(f);

    // Left and right together cancel; releasing right lets left through.
    f = '0;
    f.ga = 1'b1;
    f.kl = 1'b1;
    f.kr = 1'b1;
    applyStimulus(f);
    applyStimulus(f);
    applyStimulus(f);
    f.kr = 1'b0;
    applyStimulus(f);

    // Game inactive: requests ignored, then arbitration resumes cleanly.
    f = '0;
    f.ga = 1'b0;
    f.clr = 1'b1;
    f.fall_mid = 1'b1;
    f.kro = 1'b1;
    applyStimulus(f);
    applyStimulus(f);
    f = '0;
    f.ga = 1'b1;
    f.kro = 1'b1;
    applyStimulus(f);

    // Reset while a rotate grant is showing: it drops at once, then two
    // ticks are needed before the next grant.
    resetDut();
    f = '0;
    f.ga = 1'b1;
    f.kro = 1'b1;
    applyStimulus(f);
    @(negedge clock);
    game_active = 1'b1;
    key_rotate = 1'b1;
    @(negedge clock);
    @(negedge clock);
    frame_tick = 1'b1;
    tick_count++;
    @(posedge clock);
    #1;
    frame_tick = 1'b0;
    checkOutput("rotate_before_reset", grant_rotate, 1'b1);
    resetn = 1'b0;
    #1;
    checkOutput("rotate_async_drop", grant_rotate, 1'b0);
    resetDut();
    applyStimulus(f);
    applyStimulus(f);

    // Randomised frames with sticky key levels so auto-repeat gets exercised.
    rga = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rk[i] = 1'b0;
    end
    for (int n = 0; n < 300; n++) begin
      if (n == 150) begin
        resetDut();
      end
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          rk[i] = !rk[i];
        end
      end
      if ($urandom_range(0, 24) == 0) begin
        rga = !rga;
      end
      f = '0;
      f.ga = rga;
      f.clr = ($urandom_range(0, 6) == 0);
      f.fall_mid = ($urandom_range(0, 3) == 0);
      f.fall_tick = ($urandom_range(0, 9) == 0);
      f.kl = rk[0];
      f.kr = rk[1];
      f.kro = rk[2];
      f.bl = ($urandom_range(0, 6) == 0);
      f.br = ($urandom_range(0, 6) == 0);
      f.bro = ($urandom_range(0, 6) == 0);
      f.bd = ($urandom_range(0, 2) == 0);
      applyStimulus(f);
    end

    repeat (4) @(negedge clock);
    checkCount("expected_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_arbiter.md
MOVE_ARBITER -- requirements
Module: move_arbiter

Interface
REQ-001 Parameter REPEAT_DELAY, default 15: frame ticks a held key waits before its first auto-repeat grant.
REQ-002 Parameter REPEAT_RATE, default 4: frame ticks between subsequent auto-repeat grants.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 frame_tick  in  1  one-cycle enable pulse at the frame rate; arbitration occurs only on cycles where it is high.
REQ-006 game_active  in  1  level; when low the block issues no grants.
REQ-007 fall_req  in  1  one-cycle gravity pulse.
REQ-008 clear_req  in  1  level; at least one completed row is pending.
REQ-009 key_left, key_right, key_rotate  in  1 each  raw key levels.
REQ-010 blocked_left, blocked_right, blocked_rotate, blocked_down  in  1 each  level; the move would collide.
REQ-011 grant_clear, grant_fall, grant_left, grant_right, grant_rotate  out  1 each  registered one-cycle grant pulses.
REQ-012 grant_lock  out  1  registered one-cycle pulse; the piece must be written into the board.
REQ-013 fall_pending  out  1  a gravity request is latched and not yet serviced.

Function
REQ-014 At most one of the grant_clear, grant_fall, grant_lock, grant_left, grant_right and grant_rotate outputs is high in any cycle.
REQ-015 A grant is asserted for exactly one cycle, in the cycle after the frame_tick cycle that selected it; with no frame_tick, all grants are 0.
REQ-016 A fall_req pulse sets fall_pending, which stays set until a grant_fall or grant_lock is issued.
REQ-017 A fall_req arriving in the same cycle that services the pending fall leaves fall_pending = 1.
REQ-018 Fixed priority on a frame_tick cycle: clear_req > fall_pending > left > right > rotate.
REQ-019 A serviced fall_pending issues grant_fall when blocked_down = 0, otherwise grant_lock.
REQ-020 A key request is eligible only when that key is armed and its blocked_* input is 0.
REQ-021 key_left and key_right both high makes both ineligible; their key FSMs do not advance.
REQ-022 Each key has its own FSM with states IDLE, ARMED, DELAY and REPEAT, plus a repeat counter CNT of width clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
REQ-023 IDLE -> ARMED on key high.
REQ-024 ARMED -> DELAY when granted, with CNT = 0.
REQ-025 In DELAY, CNT increments on each frame_tick; reaching REPEAT_DELAY makes the key re-armed.
REQ-026 A DELAY key granted while re-armed moves to REPEAT with CNT = 0.
REQ-027 In REPEAT, CNT increments on each frame_tick; reaching REPEAT_RATE makes the key re-armed.
REQ-028 A REPEAT key granted while re-armed restarts REPEAT with CNT = 0.
REQ-029 A key request that is armed but loses arbitration or is blocked stays armed and is not lost; CNT saturates.
REQ-030 Key low in any state -> IDLE and CNT = 0 on the next clock.
REQ-031 A key press shorter than one clock between frame ticks is not required to be captured.
REQ-032 A clear_req grant does not clear fall_pending.
REQ-033 game_active = 0: grants are 0, fall_pending is cleared, and all key FSMs are forced to IDLE.
REQ-034 game_active rising: arbitration resumes on the next frame_tick with no stale grant.

Reset
REQ-035 resetn low immediately and asynchronously drives all grants, grant_lock and fall_pending to 0, all key FSMs to IDLE and CNT to 0.
REQ-036 Reset asserted mid-grant truncates the pulse.
REQ-037 The first grant after resetn rises issues no earlier than the second frame_tick edge after release.

Verification
REQ-038 Hold key_left for 40 frame ticks, unblocked, with no other requests -> grant_left after ticks 1, 16, 20, 24, 28, 32, 36 and 40 (7+1 pulses).
REQ-039 fall_req and key_right pressed in the same frame, blocked_down = 0 -> grant_fall on tick N; grant_right on tick N+1.
REQ-040 fall_req with blocked_down = 1 -> grant_lock only, no grant_fall; fall_pending = 0 afterwards.
REQ-041 clear_req held for 3 ticks while fall_pending = 1 -> 3 grant_clear pulses, then grant_fall; fall_pending is held throughout.
REQ-042 key_left and key_right both held -> zero left/right grants; release key_right -> grant_left on the next tick.
REQ-043 resetn pulsed low in the cycle a grant_rotate is high -> the output drops within the same cycle and no grant follows until 2 ticks after release.
